// File: rtl/v2f_ram_pkg.sv
// Shared constants for the v2f RAM write-side loader: FSM encoding and word geometry.
package v2f_ram_pkg;

  localparam int unsigned DBITS      = 32;
  localparam int unsigned BYTE_LANES = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/v2f_ram_stream_loader_if.sv
// Command, byte-stream and RAM write-port signals of the v2f stream loader.
interface v2f_ram_stream_loader_if
  import v2f_ram_pkg::*;
#(
  parameter int unsigned ABITS = 3,
  parameter int unsigned CBITS = 6
);

  logic                  START;
  logic [ABITS-1:0]      START_ADDR;
  logic [CBITS-1:0]      BYTE_COUNT;
  logic [7:0]            IN_DATA;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [ABITS-1:0]      WR_ADDR;
  logic [DBITS-1:0]      WR_DATA;
  logic                  WR_EN;
  logic [BYTE_LANES-1:0] BYTE_SELECT;
  logic                  BUSY;
  logic                  DONE;

  // master: the loader itself; slave: the command/stream source and RAM side
  modport master (
    input  START, START_ADDR, BYTE_COUNT, IN_DATA, IN_VALID,
    output IN_READY, WR_ADDR, WR_DATA, WR_EN, BYTE_SELECT, BUSY, DONE
  );

  modport slave (
    output START, START_ADDR, BYTE_COUNT, IN_DATA, IN_VALID,
    input  IN_READY, WR_ADDR, WR_DATA, WR_EN, BYTE_SELECT, BUSY, DONE
  );

endinterface

// File: rtl/v2f_programmable_ram.sv
// Word-wide RAM with byte-lane write enables and an asynchronous read port.
module v2f_programmable_ram
  import v2f_ram_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned ABITS = 3
) (
  input  logic                  CLK,
  input  logic [ABITS-1:0]      WR_ADDR,
  input  logic [DBITS-1:0]      WR_DATA,
  input  logic                  WR_EN,
  input  logic [BYTE_LANES-1:0] BYTE_SELECT,
  input  logic [ABITS-1:0]      RD_ADDR,
  output logic [DBITS-1:0]      RD_DATA
);

  logic [DBITS-1:0] mem [SIZE];

  always_ff @(posedge CLK) begin
    if (WR_EN) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (BYTE_SELECT[i]) mem[WR_ADDR][8*i +: 8] <= WR_DATA[8*i +: 8];
      end
    end
  end

  assign RD_DATA = mem[RD_ADDR];

endmodule

// File: rtl/v2f_ram_stream_loader.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and writes them to the v2f RAM.
module v2f_ram_stream_loader
  import v2f_ram_pkg::*;
#(
  parameter int unsigned ABITS = 3,
  parameter int unsigned CBITS = 6
) (
  input logic                      CLK,
  input logic                      ARST_N,
  v2f_ram_stream_loader_if.master  bus
);

  logic [1:0]            state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [CBITS-1:0]      remaining_q, remaining_d;
  logic [ABITS-1:0]      addr_q, addr_d;
  logic [DBITS-1:0]      pack_q, pack_d;
  logic [BYTE_LANES-1:0] mask_q, mask_d;
  logic [ABITS-1:0]      wr_addr_q, wr_addr_d;
  logic [DBITS-1:0]      wr_data_q, wr_data_d;
  logic [BYTE_LANES-1:0] byte_sel_q, byte_sel_d;
  logic                  done_q, done_d;
  logic                  handshake;

  assign handshake = bus.IN_VALID && (state_q == ST_LOAD);

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    pack_d      = pack_q;
    mask_d      = mask_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    byte_sel_d  = byte_sel_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          if (bus.BYTE_COUNT != '0) begin
            addr_d      = bus.START_ADDR;
            remaining_d = bus.BYTE_COUNT;
            lane_d      = '0;
            pack_d      = '0;
            mask_d      = '0;
            state_d     = ST_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          pack_d      = pack_q | (DBITS'(bus.IN_DATA) << {lane_q, 3'b000});
          mask_d      = mask_q | (BYTE_LANES'(1) << lane_q);
          lane_d      = lane_q + 2'd1;
          remaining_d = remaining_q - CBITS'(1);
          if (lane_q == 2'd3 || remaining_q == CBITS'(1)) begin
            // Output registers capture the word now so they hold it after WRITE clears the packer
            wr_addr_d  = addr_q;
            wr_data_d  = pack_d;
            byte_sel_d = mask_d;
            state_d    = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ABITS'(1);
        lane_d = '0;
        pack_d = '0;
        mask_d = '0;
        if (remaining_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      pack_q      <= '0;
      mask_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      byte_sel_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      pack_q      <= pack_d;
      mask_q      <= mask_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      byte_sel_q  <= byte_sel_d;
      done_q      <= done_d;
    end
  end

  assign bus.IN_READY    = (state_q == ST_LOAD);
  assign bus.WR_EN       = (state_q == ST_WRITE);
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.DONE        = done_q;
  assign bus.WR_ADDR     = wr_addr_q;
  assign bus.WR_DATA     = wr_data_q;
  assign bus.BYTE_SELECT = byte_sel_q;

endmodule

// File: tb/tb_v2f_ram_stream_loader.sv
// Directed bench: loader in front of the v2f RAM, checked via write-port log and RAM read port.
module tb_v2f_ram_stream_loader;
  import v2f_ram_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] ws[$];
  int ready_viol = 0;
  int done_cnt = 0;
  int done_busy = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;

  v2f_ram_stream_loader_if #(.ABITS(3), .CBITS(6)) bus ();

  v2f_ram_stream_loader #(.ABITS(3), .CBITS(6)) dut (
    .CLK    (clk),
    .ARST_N (arst_n),
    .bus    (bus)
  );

  v2f_programmable_ram #(.SIZE(8), .ABITS(3)) ram (
    .CLK         (clk),
    .WR_ADDR     (bus.WR_ADDR),
    .WR_DATA     (bus.WR_DATA),
    .WR_EN       (bus.WR_EN),
    .BYTE_SELECT (bus.BYTE_SELECT),
    .RD_ADDR     (rd_addr),
    .RD_DATA     (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write-port and DONE monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.WR_EN === 1'b1) begin
      wa.push_back(32'(bus.WR_ADDR));
      wd.push_back(bus.WR_DATA);
      ws.push_back(32'(bus.BYTE_SELECT));
      last_wr_cyc = cyc;
      if (bus.IN_READY !== 1'b0) ready_viol++;
    end
    if (bus.DONE === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (bus.BUSY !== 1'b0) done_busy++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ws.delete();
  endtask

  task automatic start_cmd(input logic [2:0] addr, input logic [5:0] count, output int scyc);
    @(negedge clk);
    bus.START      = 1'b1;
    bus.START_ADDR = addr;
    bus.BYTE_COUNT = count;
    scyc = cyc;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  // Stream n bytes base, base+step, ...; stall applies valid pattern 1,0,0,1 per cycle
  task automatic stream(input int n, input logic [7:0] base, input logic [7:0] step,
                        input bit stall);
    int i = 0;
    int k = 0;
    while (i < n && k < 200) begin
      @(negedge clk);
      bus.IN_VALID = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      bus.IN_DATA  = 8'(base + step * 8'(i));
      if (bus.IN_VALID && bus.IN_READY) i++;
      k++;
    end
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    if (i != n) check("stream_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k = 0;
    while (done_cnt == d0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic read_ram(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    int scyc;
    int d0;
    bus.START      = 1'b0;
    bus.START_ADDR = '0;
    bus.BYTE_COUNT = '0;
    bus.IN_DATA    = '0;
    bus.IN_VALID   = 1'b0;

    // Reset state
    #12;
    check("rst_outputs",
          {bus.IN_READY, bus.WR_EN, bus.BUSY, bus.DONE, 1'b0, bus.WR_ADDR, bus.BYTE_SELECT},
          32'd0);
    check("rst_wr_data", bus.WR_DATA, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Full words
    clear_log();
    d0 = done_cnt;
    start_cmd(3'd2, 6'd8, scyc);
    stream(8, 8'h11, 8'h11, 1'b0);
    wait_done(d0, "full_done");
    #1;
    check("full_wr_count", 32'(wa.size()), 32'd2);
    check("full_addr0", wa[0], 32'd2);
    check("full_data0", wd[0], 32'h44332211);
    check("full_sel0", ws[0], 32'hF);
    check("full_addr1", wa[1], 32'd3);
    check("full_data1", wd[1], 32'h88776655);
    check("full_sel1", ws[1], 32'hF);
    check("full_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);
    read_ram(3'd2, 32'h44332211, "full_rd2");
    read_ram(3'd3, 32'h88776655, "full_rd3");

    // Pre-program addr 1, then partial tail over it
    d0 = done_cnt;
    start_cmd(3'd1, 6'd4, scyc);
    stream(4, 8'hAA, 8'h11, 1'b0);
    wait_done(d0, "pre_done");
    read_ram(3'd1, 32'hDDCCBBAA, "pre_rd1");
    clear_log();
    d0 = done_cnt;
    start_cmd(3'd0, 6'd6, scyc);
    stream(6, 8'h01, 8'h01, 1'b0);
    wait_done(d0, "tail_done");
    #1;
    check("tail_wr_count", 32'(wa.size()), 32'd2);
    check("tail_data0", wd[0], 32'h04030201);
    check("tail_sel0", ws[0], 32'hF);
    check("tail_addr1", wa[1], 32'd1);
    check("tail_data1", wd[1], 32'h00000605);
    check("tail_sel1", ws[1], 32'h3);
    read_ram(3'd0, 32'h04030201, "tail_rd0");
    read_ram(3'd1, 32'hDDCC0605, "tail_rd1");

    // Wrap and stalls
    clear_log();
    d0 = done_cnt;
    start_cmd(3'd7, 6'd8, scyc);
    stream(8, 8'h11, 8'h11, 1'b1);
    wait_done(d0, "wrap_done");
    #1;
    check("wrap_wr_count", 32'(wa.size()), 32'd2);
    check("wrap_addr0", wa[0], 32'd7);
    check("wrap_data0", wd[0], 32'h44332211);
    check("wrap_addr1", wa[1], 32'd0);
    check("wrap_data1", wd[1], 32'h88776655);
    check("ready_on_wr_en", 32'(ready_viol), 32'd0);
    read_ram(3'd0, 32'h88776655, "wrap_rd0");
    read_ram(3'd7, 32'h44332211, "wrap_rd7");

    // Zero count
    clear_log();
    d0 = done_cnt;
    start_cmd(3'd5, 6'd0, scyc);
    wait_done(d0, "zero_done");
    check("zero_done_lat", 32'(done_cyc - scyc), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("zero_no_write", 32'(wa.size()), 32'd0);
    check("zero_done_once", 32'(done_cnt - d0), 32'd1);

    // START during LOAD is ignored
    clear_log();
    d0 = done_cnt;
    start_cmd(3'd4, 6'd4, scyc);
    stream(2, 8'hA1, 8'h01, 1'b0);
    @(negedge clk);
    bus.START      = 1'b1;
    bus.START_ADDR = 3'd6;
    bus.BYTE_COUNT = 6'd8;
    @(negedge clk);
    bus.START = 1'b0;
    stream(2, 8'hA3, 8'h01, 1'b0);
    wait_done(d0, "ign_done");
    repeat (4) @(negedge clk);
    #1;
    check("ign_wr_count", 32'(wa.size()), 32'd1);
    check("ign_addr", wa[0], 32'd4);
    check("ign_data", wd[0], 32'hA4A3A2A1);
    check("ign_busy", 32'(bus.BUSY), 32'd0);
    read_ram(3'd4, 32'hA4A3A2A1, "ign_rd4");

    // Reset mid-command
    clear_log();
    start_cmd(3'd5, 6'd8, scyc);
    stream(5, 8'h11, 8'h11, 1'b0);
    #1;
    check("mid_busy", 32'(bus.BUSY), 32'd1);
    check("mid_wr_data", bus.WR_DATA, 32'h44332211);
    arst_n = 1'b0;
    #1;
    check("rst_async_ctl", {28'd0, bus.IN_READY, bus.WR_EN, bus.BUSY, bus.DONE}, 32'd0);
    check("rst_async_addr_sel", {25'd0, bus.WR_ADDR, bus.BYTE_SELECT}, 32'd0);
    check("rst_async_data", bus.WR_DATA, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_one_write", 32'(wa.size()), 32'd1);
    @(negedge clk);
    arst_n = 1'b1;
    clear_log();
    d0 = done_cnt;
    start_cmd(3'd3, 6'd4, scyc);
    stream(4, 8'h01, 8'h01, 1'b0);
    wait_done(d0, "post_rst_done");
    #1;
    check("post_rst_count", 32'(wa.size()), 32'd1);
    check("post_rst_data", wd[0], 32'h04030201);
    read_ram(3'd3, 32'h04030201, "post_rst_rd3");
    read_ram(3'd5, 32'h44332211, "post_rst_rd5");
    check("done_while_busy", 32'(done_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/v2f_ram_stream_loader.md
Name: v2f_ram_stream_loader

Overview:
- Write-side master for the v2f programmable RAM write port.
- Accepts a valid/ready byte stream and packs bytes little-endian into 32-bit words.
- Drives WR_ADDR/WR_DATA/WR_EN/BYTE_SELECT so RAM contents can be loaded at runtime instead of only from PROGRAM_FILE.
- A final partial word is written with a partial byte mask.

Parameters:
ABITS, 3, RAM address width; addresses wrap modulo 2^ABITS.
CBITS, 6, width of the BYTE_COUNT command field; must be >= ABITS+3.

Ports:
CLK  input  1  single clock; all state changes on the rising edge.
ARST_N  input  1  asynchronous active-low reset.
START  input  1  one-cycle command strobe; sampled only in IDLE.
START_ADDR  input  ABITS  first word address, latched on an accepted START.
BYTE_COUNT  input  CBITS  bytes to load, latched on an accepted START.
IN_DATA  input  8  stream byte.
IN_VALID  input  1  stream byte valid.
IN_READY  output  1  loader can accept a byte this cycle.
WR_ADDR  output  ABITS  RAM write address.
WR_DATA  output  32  RAM write data.
WR_EN  output  1  RAM write strobe, one cycle per word.
BYTE_SELECT  output  4  RAM byte-lane enables.
BUSY  output  1  high in LOAD and WRITE.
DONE  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (ARST_N low, asynchronous):
  - State goes to IDLE.
  - All outputs 0: IN_READY, WR_EN, BUSY, DONE, WR_ADDR, WR_DATA, BYTE_SELECT.
  - Byte lane index, remaining count and pack register cleared.
  - Reset asserted mid-command abandons the command; no further writes occur.
- States: IDLE, LOAD, WRITE.
- IDLE:
  - START=1 and BYTE_COUNT!=0: latch address and count, clear lane index and pack register, go to LOAD.
  - START=1 and BYTE_COUNT==0: pulse DONE next cycle, no write, stay IDLE.
  - START outside IDLE is ignored.
- LOAD:
  - IN_READY=1.
  - Handshake is IN_VALID & IN_READY. On each handshake:
    - Byte goes into lane L (bits 8L+7:8L).
    - Mask bit L is set.
    - L increments.
    - Remaining count decrements.
  - A handshake with L==3 or remaining==1 moves to WRITE. Only the lanes filled so far carry valid data.
  - IN_VALID low stalls indefinitely with no timeout.
- WRITE (exactly one cycle):
  - WR_EN=1, IN_READY=0.
  - WR_ADDR = current address, WR_DATA = pack register, BYTE_SELECT = accumulated mask.
  - Unfilled lanes of WR_DATA are 0.
  - Next cycle:
    - Address increments modulo 2^ABITS (7 wraps to 0).
    - L, mask and pack register clear.
    - If remaining==0: go to IDLE and pulse DONE on that cycle. Otherwise go back to LOAD.
- Latency and throughput:
  - WR_EN is high the cycle after the handshake that completes a word.
  - Peak throughput is 4 bytes per 5 cycles.
  - DONE is high the cycle after the last WR_EN.
- WR_ADDR, WR_DATA and BYTE_SELECT are registered and hold their last values when WR_EN=0. Only WR_EN qualifies them.
- BUSY = (state != IDLE). DONE is never high while BUSY is high.
- A BYTE_COUNT larger than 4*2^ABITS wraps the address and overwrites earlier words; this is legal.

Decomposition:
- Shared package v2f_ram_pkg holds:
  - state encoding constants: ST_IDLE=0, ST_LOAD=1, ST_WRITE=2
  - BYTE_LANES=4
  - the DBITS=32 constant
- Single module with no sub-modules. The byte packer is inline.
- The bench instantiates it in front of v2f_programmable_ram (SIZE=8, ABITS=3) and checks results through the RAM read port.

Test Plan:
- Full words:
  - Stimulus: reset, then START with START_ADDR=2, BYTE_COUNT=8; stream 11,22,33,44,55,66,77,88 (hex) with IN_VALID held high.
  - Required: writes 0x44332211 to addr 2 and 0x88776655 to addr 3, BYTE_SELECT=F on both; DONE one cycle after the second WR_EN; RD_ADDR=2 reads 0x44332211.
- Partial tail:
  - Stimulus: START_ADDR=0, BYTE_COUNT=6; bytes 01..06.
  - Required: addr 0 gets 0x04030201 with BYTE_SELECT=F; addr 1 gets WR_DATA=0x00000605 with BYTE_SELECT=3; pre-programmed upper bytes of addr 1 are preserved on read.
- Wrap and stalls:
  - Stimulus: START_ADDR=7, BYTE_COUNT=8; IN_VALID toggled 1,0,0,1 per cycle.
  - Required: second word goes to addr 0; write count and data match the no-stall case; IN_READY=0 on every WR_EN cycle.
- Zero count and ignored START:
  - Stimulus: START with BYTE_COUNT=0.
  - Required: DONE one cycle later, no WR_EN.
  - Stimulus: START pulsed during LOAD.
  - Required: ignored; the original command completes unchanged.
- Reset mid-command:
  - Stimulus: BYTE_COUNT=8; drop ARST_N after 5 bytes.
  - Required: all outputs 0 immediately (asynchronously); only one write (the first word) occurred; a new START after release behaves normally.
